management_tx_framer: RTL

//  Transmit-side counterpart of the management RX frame FIFO. Firmware pushes outbound frame bytes over the byte-wide

---
 rtl/management_tx_framer_pkg.sv | 29 ++
 rtl/mgmt_sync_fifo.sv | 39 +++
 rtl/management_tx_framer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/management_tx_framer_pkg.sv
// Shared types for the management TX path: FSM states, the MAC-facing TX bus and byte packing.
package management_tx_framer_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA} mgmt_tx_state_t;

  localparam int MGMT_MAX_FRAME_LEN = 1518;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
  } ethernet_tx_bus_t;

  // Big-endian packing: lane 0 is the first byte on the wire.
  function automatic logic [31:0] place_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mgmt_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; holds DEPTH-1 entries.
module mgmt_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg + AW'(1)) == rd_ptr_reg);
  assign dout  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

endmodule

// File: rtl/management_tx_framer.sv
// Buffers firmware-written management frames and streams committed frames onto the mgmt0 TX bus.
module management_tx_framer
  import management_tx_framer_pkg::*;
#(
  parameter int DATA_DEPTH = 1024,
  parameter int LEN_DEPTH  = 16,
  parameter int MAX_LEN    = MGMT_MAX_FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_commit,
  input  logic                          wr_drop,
  output logic                          wr_overflow,
  output logic [$clog2(DATA_DEPTH):0]   buf_free_words,
  input  logic                          link_up,
  input  logic                          tx_ready,
  output ethernet_tx_bus_t              tx_bus,
  output logic                          tx_busy,
  output logic [31:0]                   frames_sent,
  output logic [31:0]                   frames_aborted
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic [31:0]    mem [DATA_DEPTH];
  logic [31:0]    ram_rdata;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  logic [31:0]    ram_wdata;

  logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]  commit_ptr_reg, commit_ptr_next;
  logic [15:0]    byte_cnt_reg, byte_cnt_next;
  logic [31:0]    word_reg, word_next;
  logic           overflow_reg, overflow_next;
  logic           full_pulse_reg, full_pulse_next;
  logic [AW:0]    free_reg;

  logic           len_push, len_pop, len_full, len_empty;
  logic [15:0]    len_dout, len_words;

  mgmt_tx_state_t   state_reg;
  ethernet_tx_bus_t tx_bus_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [15:0]      reads_left_reg, sends_left_reg;
  logic [2:0]       last_bytes_reg;
  logic [31:0]      frames_sent_reg, frames_aborted_reg;
  logic             rd_adv;

  mgmt_sync_fifo #(.WIDTH(16), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk(clk), .rst(rst), .push(len_push), .din(byte_cnt_next), .pop(len_pop),
    .dout(len_dout), .full(len_full), .empty(len_empty)
  );

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    overflow_next   = overflow_reg;
    full_pulse_next = 1'b0;
    ram_we          = 1'b0;
    ram_waddr       = wr_ptr_reg;
    ram_wdata       = word_reg;
    len_push        = 1'b0;
    if (wr_drop) begin
      wr_ptr_next   = commit_ptr_reg;
      byte_cnt_next = '0;
      word_next     = '0;
      overflow_next = 1'b0;
    end else begin
      if (wr_en && !overflow_reg) begin
        // Room for a word is claimed on its first byte so the zero-padded tail always fits.
        if (byte_cnt_reg >= MAX_LEN_W ||
            (byte_cnt_reg[1:0] == 2'd0 && (wr_ptr_reg + AW'(1)) == rd_ptr_reg)) begin
          overflow_next = 1'b1;
        end else begin
          word_next     = place_byte(word_reg, byte_cnt_reg[1:0], wr_data);
          byte_cnt_next = byte_cnt_reg + 16'd1;
          if (byte_cnt_reg[1:0] == 2'd3) begin
            ram_we      = 1'b1;
            ram_wdata   = word_next;
            wr_ptr_next = wr_ptr_reg + AW'(1);
            word_next   = '0;
          end
        end
      end
      if (wr_commit) begin
        if (overflow_next || (byte_cnt_next != 16'd0 && len_full)) begin
          full_pulse_next = !overflow_next;
          wr_ptr_next     = commit_ptr_reg;
          byte_cnt_next   = '0;
          word_next       = '0;
          overflow_next   = 1'b0;
        end else if (byte_cnt_next != 16'd0) begin
          if (byte_cnt_next[1:0] != 2'd0) begin
            ram_we      = 1'b1;
            ram_wdata   = word_next;
            wr_ptr_next = wr_ptr_reg + AW'(1);
          end
          len_push        = 1'b1;
          commit_ptr_next = wr_ptr_next;
          word_next       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
      overflow_reg   <= 1'b0;
      full_pulse_reg <= 1'b0;
      free_reg       <= (AW+1)'(DATA_DEPTH - 1);
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      byte_cnt_reg   <= len_push ? 16'd0 : byte_cnt_next;
      word_reg       <= word_next;
      overflow_reg   <= overflow_next;
      full_pulse_reg <= full_pulse_next;
      free_reg       <= {1'b0, rd_ptr_reg - wr_ptr_reg - AW'(1)};
    end
  end

  assign len_pop   = (state_reg == IDLE) && !len_empty && link_up && tx_ready;
  assign len_words = (len_dout + 16'd3) >> 2;
  assign rd_adv    = len_pop ||
                     ((state_reg != IDLE) && link_up && reads_left_reg != 16'd0);

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (rd_adv) ram_rdata <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      tx_bus_reg         <= '0;
      rd_ptr_reg         <= '0;
      reads_left_reg     <= '0;
      sends_left_reg     <= '0;
      last_bytes_reg     <= '0;
      frames_sent_reg    <= '0;
      frames_aborted_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_bus_reg <= '0;
          if (len_pop) begin
            tx_bus_reg.start <= 1'b1;
            rd_ptr_reg       <= rd_ptr_reg + AW'(1);
            reads_left_reg   <= len_words - 16'd1;
            sends_left_reg   <= len_words;
            last_bytes_reg   <= (len_dout[1:0] == 2'd0) ? 3'd4 : {1'b0, len_dout[1:0]};
            state_reg        <= START;
          end
        end
        START, DATA: begin
          if (!link_up) begin
            // Skip the unsent remainder so the next queued frame starts at its own first word.
            tx_bus_reg         <= '0;
            rd_ptr_reg         <= rd_ptr_reg + reads_left_reg[AW-1:0];
            reads_left_reg     <= '0;
            sends_left_reg     <= '0;
            frames_aborted_reg <= frames_aborted_reg + 32'd1;
            state_reg          <= IDLE;
          end else if (sends_left_reg == 16'd0) begin
            tx_bus_reg      <= '0;
            frames_sent_reg <= frames_sent_reg + 32'd1;
            state_reg       <= IDLE;
          end else begin
            tx_bus_reg.start       <= 1'b0;
            tx_bus_reg.data_valid  <= 1'b1;
            tx_bus_reg.bytes_valid <= (sends_left_reg == 16'd1) ? last_bytes_reg : 3'd4;
            tx_bus_reg.data        <= ram_rdata;
            sends_left_reg         <= sends_left_reg - 16'd1;
            if (reads_left_reg != 16'd0) begin
              rd_ptr_reg     <= rd_ptr_reg + AW'(1);
              reads_left_reg <= reads_left_reg - 16'd1;
            end
            state_reg <= DATA;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_bus         = tx_bus_reg;
  assign tx_busy        = (state_reg != IDLE);
  assign frames_sent    = frames_sent_reg;
  assign frames_aborted = frames_aborted_reg;
  assign wr_overflow    = overflow_reg | full_pulse_reg;
  assign buf_free_words = free_reg;

endmodule
